// File: rtl/circle_pkg.sv
// Shared coordinate types for the circle renderer and its endpoint update scheduler.
package circle_pkg;

  localparam int COORD_X_W = 11;
  localparam int COORD_Y_W = 10;

  typedef struct packed {
    logic [COORD_X_W-1:0] x1;
    logic [COORD_Y_W-1:0] y1;
    logic [COORD_X_W-1:0] x2;
    logic [COORD_Y_W-1:0] y2;
  } circle_coords_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1 (mod N).
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    // Walk from farthest to nearest so the nearest candidate after ptr wins.
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (enable && req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/circle_update_scheduler.sv
// Arbitrates endpoint updates into a single pending slot and commits it to the renderer
// only on the frame-boundary pixel, so a circle never changes mid-frame.
module circle_update_scheduler
  import circle_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int FRAME_LINE  = 720,
  parameter int LAST_HCOUNT = 1649,
  parameter int LAST_VCOUNT = 749
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic [N_REQ-1:0]         req_valid_in,
  input  logic [N_REQ*11-1:0]      req_x1_in,
  input  logic [N_REQ*10-1:0]      req_y1_in,
  input  logic [N_REQ*11-1:0]      req_x2_in,
  input  logic [N_REQ*10-1:0]      req_y2_in,
  output logic [N_REQ-1:0]         req_ready_out,
  input  logic                     hold_in,
  output logic [10:0]              x_out_1,
  output logic [9:0]               y_out_1,
  output logic [10:0]              x_out_2,
  output logic [9:0]               y_out_2,
  output logic                     visible_out,
  output logic                     commit_out,
  output logic [$clog2(N_REQ)-1:0] src_out,
  output logic                     pending_out
);

  localparam int IW = $clog2(N_REQ);

  sched_state_e   state_q, state_d;
  circle_coords_t pend_q, pend_d;
  circle_coords_t out_q, out_d;
  logic [IW-1:0]  pend_src_q, pend_src_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  src_q, src_d;
  logic           vis_q, vis_d;
  logic           commit_q, commit_d;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_vld;
  logic             boundary;
  circle_coords_t   sel;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req       (req_valid_in),
    .ptr       (ptr_q),
    .enable    (state_q == ST_IDLE),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Out-of-range counters can never equal the commit pixel, so they simply never commit.
  assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'(FRAME_LINE))
                    && (int'(hcount_in) <= LAST_HCOUNT) && (int'(vcount_in) <= LAST_VCOUNT);

  always_comb begin
    sel.x1 = req_x1_in[int'(grant_idx)*COORD_X_W +: COORD_X_W];
    sel.y1 = req_y1_in[int'(grant_idx)*COORD_Y_W +: COORD_Y_W];
    sel.x2 = req_x2_in[int'(grant_idx)*COORD_X_W +: COORD_X_W];
    sel.y2 = req_y2_in[int'(grant_idx)*COORD_Y_W +: COORD_Y_W];
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_src_d = pend_src_q;
    ptr_d      = ptr_q;
    out_d      = out_q;
    src_d      = src_q;
    vis_d      = vis_q;
    commit_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          pend_d     = sel;
          pend_src_d = grant_idx;
          ptr_d      = grant_idx;
          state_d    = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (boundary && !hold_in) begin
          out_d    = pend_q;
          src_d    = pend_src_q;
          vis_d    = 1'b1;
          commit_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      pend_src_q <= '0;
      ptr_q      <= IW'(N_REQ - 1);
      out_q      <= '0;
      src_q      <= '0;
      vis_q      <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      ptr_q      <= ptr_d;
      out_q      <= out_d;
      src_q      <= src_d;
      vis_q      <= vis_d;
      commit_q   <= commit_d;
    end
  end

  assign req_ready_out = grant;
  assign x_out_1       = out_q.x1;
  assign y_out_1       = out_q.y1;
  assign x_out_2       = out_q.x2;
  assign y_out_2       = out_q.y2;
  assign src_out       = src_q;
  assign visible_out   = vis_q;
  assign commit_out    = commit_q;
  assign pending_out   = (state_q == ST_PENDING);

endmodule

// File: tb/tb_circle_update_scheduler.sv
// Directed bench for circle_update_scheduler; frame timing is emulated by driving h/v directly.
module tb_circle_update_scheduler;

  localparam int N = 3;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [10:0]     hcount_in;
  logic [9:0]      vcount_in;
  logic [N-1:0]    req_valid_in;
  logic [N*11-1:0] req_x1_in;
  logic [N*10-1:0] req_y1_in;
  logic [N*11-1:0] req_x2_in;
  logic [N*10-1:0] req_y2_in;
  logic [N-1:0]    req_ready_out;
  logic            hold_in;
  logic [10:0]     x_out_1;
  logic [9:0]      y_out_1;
  logic [10:0]     x_out_2;
  logic [9:0]      y_out_2;
  logic            visible_out;
  logic            commit_out;
  logic [1:0]      src_out;
  logic            pending_out;

  int n_chk = 0;
  int n_err = 0;

  circle_update_scheduler #(.N_REQ(N)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .req_valid_in  (req_valid_in),
    .req_x1_in     (req_x1_in),
    .req_y1_in     (req_y1_in),
    .req_x2_in     (req_x2_in),
    .req_y2_in     (req_y2_in),
    .req_ready_out (req_ready_out),
    .hold_in       (hold_in),
    .x_out_1       (x_out_1),
    .y_out_1       (y_out_1),
    .x_out_2       (x_out_2),
    .y_out_2       (y_out_2),
    .visible_out   (visible_out),
    .commit_out    (commit_out),
    .src_out       (src_out),
    .pending_out   (pending_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input int x1, input int y1, input int x2, input int y2);
    req_x1_in[i*11 +: 11] = 11'(x1);
    req_y1_in[i*10 +: 10] = 10'(y1);
    req_x2_in[i*11 +: 11] = 11'(x2);
    req_y2_in[i*10 +: 10] = 10'(y2);
  endtask

  task automatic mid_frame();
    hcount_in = 11'd100;
    vcount_in = 10'd300;
  endtask

  task automatic on_boundary();
    hcount_in = 11'd0;
    vcount_in = 10'd720;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input int x1, input int y1, input int x2,
                          input int y2, input int src, input int vis);
    chk({tag, ".x1"},  32'(x_out_1), 32'(x1));
    chk({tag, ".y1"},  32'(y_out_1), 32'(y1));
    chk({tag, ".x2"},  32'(x_out_2), 32'(x2));
    chk({tag, ".y2"},  32'(y_out_2), 32'(y2));
    chk({tag, ".src"}, 32'(src_out), 32'(src));
    chk({tag, ".vis"}, 32'(visible_out), 32'(vis));
  endtask

  initial begin
    int exp_src [6] = '{0, 1, 2, 0, 1, 2};
    rst_in       = 1'b1;
    hold_in      = 1'b0;
    req_valid_in = '0;
    req_x1_in    = '0;
    req_y1_in    = '0;
    req_x2_in    = '0;
    req_y2_in    = '0;
    mid_frame();
    do_reset();

    // reset state and idle frames
    chk_outs("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.commit",  32'(commit_out), 0);
    chk("rst.pending", 32'(pending_out), 0);
    chk("rst.ready",   32'(req_ready_out), 0);
    for (int f = 0; f < 2; f++) begin
      on_boundary();
      step();
      mid_frame();
      chk("idle.commit", 32'(commit_out), 0);
      chk("idle.vis",    32'(visible_out), 0);
      step();
      chk("idle.commit2", 32'(commit_out), 0);
    end

    // single request from requester 1
    set_req(1, 100, 200, 300, 200);
    req_valid_in = 3'b010;
    #1;
    chk("r1.ready", 32'(req_ready_out), 32'b010);
    step();
    req_valid_in = '0;
    chk("r1.pending", 32'(pending_out), 1);
    chk("r1.commit_early", 32'(commit_out), 0);
    chk("r1.ready_pend", 32'(req_ready_out), 0);
    step();
    on_boundary();
    step();
    mid_frame();
    chk("r1.commit", 32'(commit_out), 1);
    chk_outs("r1", 100, 200, 300, 200, 1, 1);
    chk("r1.pending_clr", 32'(pending_out), 0);
    step();
    chk("r1.commit_pulse", 32'(commit_out), 0);
    chk("r1.hold_x1", 32'(x_out_1), 100);

    // fairness: all three continuously valid from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 10 + i, 20 + i, 30 + i, 40 + i);
    req_valid_in = 3'b111;
    for (int f = 0; f < 6; f++) begin
      mid_frame();
      #1;
      chk("rr.ready", 32'(req_ready_out), 32'(1 << exp_src[f]));
      step();
      chk("rr.ready_pend", 32'(req_ready_out), 0);
      step();
      on_boundary();
      step();
      mid_frame();
      chk("rr.commit", 32'(commit_out), 1);
      chk("rr.src", 32'(src_out), 32'(exp_src[f]));
      chk("rr.x1", 32'(x_out_1), 32'(10 + exp_src[f]));
      chk("rr.y2", 32'(y_out_2), 32'(40 + exp_src[f]));
    end
    req_valid_in = '0;
    step();

    // request arriving exactly on the boundary cycle
    set_req(2, 50, 60, 70, 80);
    req_valid_in = 3'b100;
    on_boundary();
    #1;
    chk("bnd.ready", 32'(req_ready_out), 32'b100);
    step();
    req_valid_in = '0;
    mid_frame();
    chk("bnd.commit", 32'(commit_out), 0);
    chk("bnd.pending", 32'(pending_out), 1);
    chk("bnd.x1_kept", 32'(x_out_1), 12);
    step();
    on_boundary();
    step();
    mid_frame();
    chk("bnd.commit2", 32'(commit_out), 1);
    chk_outs("bnd", 50, 60, 70, 80, 2, 1);

    // hold across a boundary, plus near-miss counters; zero radius passes through
    set_req(0, 400, 300, 400, 300);
    req_valid_in = 3'b111;
    #1;
    chk("hold.ready", 32'(req_ready_out), 32'b001);
    step();
    req_valid_in = '0;
    hold_in = 1'b1;
    on_boundary();
    step();
    chk("hold.commit", 32'(commit_out), 0);
    chk("hold.pending", 32'(pending_out), 1);
    chk("hold.x1", 32'(x_out_1), 50);
    hold_in = 1'b0;
    hcount_in = 11'd1;
    step();
    hcount_in = 11'd0;
    vcount_in = 10'd719;
    step();
    hcount_in = 11'd0;
    vcount_in = 10'd1000;
    step();
    chk("near.commit", 32'(commit_out), 0);
    chk("near.pending", 32'(pending_out), 1);
    on_boundary();
    step();
    mid_frame();
    chk("rel.commit", 32'(commit_out), 1);
    chk_outs("rel", 400, 300, 400, 300, 0, 1);

    // reset while pending, one cycle before the boundary
    set_req(1, 5, 6, 7, 8);
    req_valid_in = 3'b010;
    #1;
    chk("rp.ready", 32'(req_ready_out), 32'b010);
    step();
    req_valid_in = '0;
    chk("rp.pending", 32'(pending_out), 1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    on_boundary();
    step();
    mid_frame();
    chk("rp.commit", 32'(commit_out), 0);
    chk("rp.pending", 32'(pending_out), 0);
    chk_outs("rp", 0, 0, 0, 0, 0, 0);
    req_valid_in = 3'b111;
    #1;
    chk("rp.ready0", 32'(req_ready_out), 32'b001);
    step();
    req_valid_in = '0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/circle_update_scheduler.md
Name: circle_update_scheduler

Overview:
- Round-robin arbiter and frame-synchronous commit controller for the circle renderer's endpoint inputs (x_in_1/y_in_1/x_in_2/y_in_2).
- Up to N_REQ requesters (camera stroke detector, physics engine, UI cursor) each offer a new endpoint pair through a valid/ready handshake.
- One accepted request is held in a single pending slot and copied to the renderer registers only at a frame boundary, so a circle never tears mid-frame.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- FRAME_LINE, 720, vcount value whose hcount==0 pixel is the commit point (first vertical-blank line of 1280x720).
- LAST_HCOUNT, 1649, maximum hcount value (used only for the range check).
- LAST_VCOUNT, 749, maximum vcount value.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- hcount_in  in  11  current pixel column
- vcount_in  in  10  current pixel row
- req_valid_in  in  N_REQ  per-requester valid
- req_x1_in  in  N_REQ*11  packed x endpoint 1, requester i at [i*11 +: 11]
- req_y1_in  in  N_REQ*10  packed y endpoint 1
- req_x2_in  in  N_REQ*11  packed x endpoint 2
- req_y2_in  in  N_REQ*10  packed y endpoint 2
- req_ready_out  out  N_REQ  one-hot accept; transfer when valid&&ready
- hold_in  in  1  1 = suppress commits; pending is kept
- x_out_1  out  11  committed endpoint to renderer
- y_out_1  out  10  committed endpoint
- x_out_2  out  11  committed endpoint
- y_out_2  out  10  committed endpoint
- visible_out  out  1  0 until first commit; gates renderer colour
- commit_out  out  1  single-cycle pulse on the cycle outputs change
- src_out  out  $clog2(N_REQ)  requester index of current committed values
- pending_out  out  1  pending slot occupied

Behaviour:
- Reset (rst_in sampled high at a clock edge):
  - all outputs 0; pending cleared; round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - An uncommitted pending request is discarded.
- Frame boundary: boundary = (hcount_in==0 && vcount_in==FRAME_LINE), evaluated combinationally on the current inputs; true for exactly one cycle per frame.
- States:
  - IDLE: pending empty.
    - If any req_valid_in bit is set, grant the first set bit searching upward from (ptr+1) mod N_REQ.
    - req_ready_out is combinational and one-hot to that requester in the same cycle.
    - On that edge, capture the granted requester's four fields and index into the pending slot; ptr <= granted index; go to PENDING.
    - A request arriving on the boundary cycle is accepted, but it commits at the next boundary, not this one.
  - PENDING: req_ready_out = 0; no accept.
    - On a boundary cycle with hold_in=0, outputs are registered from the pending slot on that edge.
    - commit_out=1 for the following cycle only; visible_out <= 1; go to IDLE.
    - With hold_in=1 on the boundary cycle, stay in PENDING; the next eligible boundary commits.
- Latency:
  - accept→commit is at most one frame plus one cycle.
  - Commit edge→outputs valid: 1 cycle.
  - At most one commit per frame.
- Outputs hold their last committed values indefinitely between commits. src_out updates together with the endpoint outputs.
- Ordering and widths:
  - Endpoint ordering is not normalised; values pass through unchanged and the renderer sorts them.
  - x1==x2 (zero radius) is legal and is passed through.
- req_valid_in dropping before grant: no capture. Valid is not required to be sticky, but a requester must hold its data stable while valid.
- Fairness: a continuously requesting requester is granted at least once in every N_REQ accepts.
- hcount_in/vcount_in beyond LAST_* never match the boundary. There is no error flag.

Decomposition:
- Shared package circle_pkg:
  - typedef circle_coords_t (x1[10:0], y1[9:0], x2[10:0], y2[9:0]).
  - COORD_X_W=11, COORD_Y_W=10.
  - The same typedef is used by the renderer wrapper.
- One natural sub-module, rr_arbiter:
  - parameter N.
  - Inputs: req[N-1:0], ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset then idle frames → visible_out=0, all coords 0, commit_out never pulses, req_ready_out=0.
- Requester 1 presents (100,200)-(300,200) mid-frame → req_ready_out=3'b010 that cycle, pending_out=1. At (h=0,v=720) edge, x_out_1=100, x_out_2=300, y_out_1=200, src_out=1, visible_out=1, one-cycle commit_out.
- All three requesters valid continuously for 6 frames → commit src_out sequence 0,1,2,0,1,2.
- Request valid exactly on the boundary cycle with pending empty → accepted that cycle; outputs unchanged at this boundary; commit at the following boundary.
- hold_in=1 across one boundary with pending set → no commit, pending_out stays 1. Release hold → commit at the next boundary with the original values.
- rst_in asserted while PENDING, one cycle before a boundary → no commit at that boundary; outputs 0, visible_out=0, next grant goes to requester 0.
